// File: rtl/wb_pkg.sv
// Shared widths and types for the integer-register writeback path.
package wb_pkg;

  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;
  localparam int NUM_REGS   = 1 << REG_ADDR_W;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;

  // One buffered long-latency result: destination plus value.
  typedef struct packed {
    reg_addr_t       rd;
    logic [XLEN-1:0] data;
  } wb_entry_t;

  // One pending bit per architectural register.
  typedef logic [NUM_REGS-1:0] busy_vec_t;

endpackage

// File: rtl/wb_fifo.sv
// Small synchronous FIFO holding LSU results until a register-file slot is free.
module wb_fifo
  import wb_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      push,
  input  wb_entry_t push_data,
  input  logic      pop,
  output logic      full,
  output logic      empty,
  output wb_entry_t head
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  wb_entry_t        mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             do_push;
  logic             do_pop;

  // Guard against overflow/underflow so a careless caller cannot corrupt state.
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  assign full  = (count == CNT_W'(DEPTH));
  assign empty = (count == '0);
  assign head  = mem[rd_ptr];

  // Pointers wrap naturally because DEPTH is a power of two; count tracks occupancy.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: ;
      endcase
    end
  end

  // Entry storage written on push.
  // NOTE: storage has no reset; the occupancy counter alone decides which entries are valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/writeback_unit.sv
// Register-file writer: merges ALU and buffered LSU results, keeps a busy scoreboard.
module writeback_unit
  import wb_pkg::*;
#(
  parameter int LSU_FIFO_DEPTH = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  issue_valid,
  input  logic [REG_ADDR_W-1:0] issue_rd,
  input  logic                  alu_valid,
  input  logic [REG_ADDR_W-1:0] alu_rd,
  input  logic [XLEN-1:0]       alu_data,
  input  logic                  lsu_valid,
  output logic                  lsu_ready,
  input  logic [REG_ADDR_W-1:0] lsu_rd,
  input  logic [XLEN-1:0]       lsu_data,
  input  logic [REG_ADDR_W-1:0] chk_rs1,
  input  logic [REG_ADDR_W-1:0] chk_rs2,
  input  logic [REG_ADDR_W-1:0] chk_rd,
  output logic                  stall,
  output logic [NUM_REGS-1:0]   busy,
  output logic                  rf_we,
  output logic [REG_ADDR_W-1:0] rf_rd,
  output logic [XLEN-1:0]       rf_wdata
);

  logic      ready_q;
  logic      fifo_full;
  logic      fifo_empty;
  wb_entry_t fifo_head;
  wb_entry_t lsu_entry;
  logic      lsu_push;
  logic      alu_sel;
  logic      fifo_pop;
  logic      lsu_write;
  busy_vec_t busy_q;
  busy_vec_t busy_next;

  assign lsu_entry = '{rd: lsu_rd, data: lsu_data};

  // ready comes only from flops so the LSU sees no combinational path back from its own valid.
  assign lsu_ready = ready_q && !fifo_full;
  assign lsu_push  = lsu_valid && lsu_ready;

  // ALU owns the slot unless it targets x0; otherwise the FIFO head drains.
  assign alu_sel   = alu_valid && (alu_rd != '0);
  assign fifo_pop  = !alu_sel && !fifo_empty;
  assign lsu_write = fifo_pop && (fifo_head.rd != '0);

  wb_fifo #(
    .DEPTH(LSU_FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (lsu_push),
    .push_data (lsu_entry),
    .pop       (fifo_pop),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .head      (fifo_head)
  );

  // Hold off the LSU while in reset; open up from the first edge after release.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) ready_q <= 1'b0;
    else      ready_q <= 1'b1;
  end

  // Scoreboard update: clear on LSU writeback, then set on issue so a same-edge set wins.
  // NOTE: combinational blocks use blocking assignments with a full default first, so no latch forms.
  always_comb begin
    busy_next = busy_q;
    if (lsu_write) busy_next[fifo_head.rd] = 1'b0;
    if (issue_valid && (issue_rd != '0)) busy_next[issue_rd] = 1'b1;
    busy_next[0] = 1'b0;
  end

  // Scoreboard register.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) busy_q <= '0;
    else      busy_q <= busy_next;
  end

  // Registered write port; address and data hold when no write is selected.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rf_we    <= 1'b0;
      rf_rd    <= '0;
      rf_wdata <= '0;
    end else begin
      rf_we <= alu_sel || lsu_write;
      if (alu_sel) begin
        rf_rd    <= alu_rd;
        rf_wdata <= alu_data;
      end else if (lsu_write) begin
        rf_rd    <= fifo_head.rd;
        rf_wdata <= fifo_head.data;
      end
    end
  end

  assign busy  = busy_q;
  assign stall = busy_q[chk_rs1] | busy_q[chk_rs2] | busy_q[chk_rd];

endmodule

// File: tb/tb_writeback_unit.sv
// Self-checking bench for writeback_unit: scoreboard of expected register-file writes.
module tb_writeback_unit;

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] data;
  } exp_t;

  logic        clk;
  logic        rst;
  logic        issue_valid;
  logic [4:0]  issue_rd;
  logic        alu_valid;
  logic [4:0]  alu_rd;
  logic [31:0] alu_data;
  logic        lsu_valid;
  logic        lsu_ready;
  logic [4:0]  lsu_rd;
  logic [31:0] lsu_data;
  logic [4:0]  chk_rs1;
  logic [4:0]  chk_rs2;
  logic [4:0]  chk_rd;
  logic        stall;
  logic [31:0] busy;
  logic        rf_we;
  logic [4:0]  rf_rd;
  logic [31:0] rf_wdata;

  int   checks = 0;
  int   passes = 0;
  exp_t exp_q[$];
  exp_t mon_e;

  writeback_unit #(
    .LSU_FIFO_DEPTH(2)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .issue_valid (issue_valid),
    .issue_rd    (issue_rd),
    .alu_valid   (alu_valid),
    .alu_rd      (alu_rd),
    .alu_data    (alu_data),
    .lsu_valid   (lsu_valid),
    .lsu_ready   (lsu_ready),
    .lsu_rd      (lsu_rd),
    .lsu_data    (lsu_data),
    .chk_rs1     (chk_rs1),
    .chk_rs2     (chk_rs2),
    .chk_rd      (chk_rd),
    .stall       (stall),
    .busy        (busy),
    .rf_we       (rf_we),
    .rf_rd       (rf_rd),
    .rf_wdata    (rf_wdata)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Every register-file write is matched in order against the expected-write queue.
  always @(negedge clk) begin
    if (rst && rf_we) begin
      checks++;
      if (exp_q.size() == 0) begin
        $display("FAIL unexpected_write: got rd=%0d data=%h, required no write", rf_rd, rf_wdata);
      end else begin
        mon_e = exp_q.pop_front();
        if (rf_rd !== mon_e.rd || rf_wdata !== mon_e.data)
          $display("FAIL write_order: got rd=%0d data=%h, required rd=%0d data=%h",
                   rf_rd, rf_wdata, mon_e.rd, mon_e.data);
        else
          passes++;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Wait a bounded number of cycles for all expected writes to appear.
  task automatic drain(input string name);
    int n = 0;
    while (exp_q.size() != 0 && n < 20) begin
      tick();
      n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      $display("FAIL %s_drain: %0d writes pending, required 0", name, exp_q.size());
      exp_q.delete();
    end else begin
      passes++;
    end
  endtask

  task automatic test_reset();
    checks++;
    if (rf_we !== 1'b0 || rf_rd !== 5'd0 || rf_wdata !== 32'd0)
      $display("FAIL reset_rf: got we=%b rd=%0d data=%h, required 0/0/0", rf_we, rf_rd, rf_wdata);
    else passes++;
    checks++;
    if (busy !== 32'd0 || lsu_ready !== 1'b0 || stall !== 1'b0)
      $display("FAIL reset_state: got busy=%h ready=%b stall=%b, required 0/0/0", busy, lsu_ready, stall);
    else passes++;
    @(posedge clk);
    #1 rst = 1'b1;
    #1;
    checks++;
    if (lsu_ready !== 1'b0) $display("FAIL ready_before_edge: got %b, required 0", lsu_ready);
    else passes++;
    tick();
    checks++;
    if (lsu_ready !== 1'b1) $display("FAIL ready_after_release: got %b, required 1", lsu_ready);
    else passes++;
  endtask

  task automatic test_alu();
    alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'h0000_00AA;
    exp_q.push_back('{rd: 5'd5, data: 32'h0000_00AA});
    tick();
    alu_valid = 1'b0;
    checks++;
    if (rf_we !== 1'b1 || rf_rd !== 5'd5 || rf_wdata !== 32'hAA)
      $display("FAIL alu_write: got we=%b rd=%0d data=%h, required 1/5/aa", rf_we, rf_rd, rf_wdata);
    else passes++;
    tick();
    checks++;
    if (rf_we !== 1'b0 || rf_rd !== 5'd5 || rf_wdata !== 32'hAA)
      $display("FAIL alu_idle_hold: got we=%b rd=%0d data=%h, required 0/5/aa", rf_we, rf_rd, rf_wdata);
    else passes++;
    drain("alu");
  endtask

  task automatic test_busy_stall();
    issue_valid = 1'b1; issue_rd = 5'd7;
    tick();
    issue_valid = 1'b0;
    checks++;
    if (busy !== 32'h0000_0080) $display("FAIL busy_set7: got %h, required 00000080", busy);
    else passes++;
    for (int k = 0; k < 3; k++) begin
      chk_rs1 = (k == 0) ? 5'd7 : 5'd2;
      chk_rs2 = (k == 1) ? 5'd7 : 5'd3;
      chk_rd  = (k == 2) ? 5'd7 : 5'd4;
      #1;
      checks++;
      if (stall !== 1'b1) $display("FAIL stall_operand%0d: got %b, required 1", k, stall);
      else passes++;
    end
    chk_rs1 = 5'd7; chk_rs2 = 5'd0; chk_rd = 5'd0;
    lsu_valid = 1'b1; lsu_rd = 5'd7; lsu_data = 32'hDEAD_BEEF;
    exp_q.push_back('{rd: 5'd7, data: 32'hDEAD_BEEF});
    tick();
    lsu_valid = 1'b0;
    checks++;
    if (busy[7] !== 1'b1 || stall !== 1'b1)
      $display("FAIL busy_held_in_fifo: got busy7=%b stall=%b, required 1/1", busy[7], stall);
    else passes++;
    tick();
    checks++;
    if (rf_we !== 1'b1 || rf_rd !== 5'd7 || busy[7] !== 1'b0 || stall !== 1'b0)
      $display("FAIL lsu_writeback: got we=%b rd=%0d busy7=%b stall=%b, required 1/7/0/0",
               rf_we, rf_rd, busy[7], stall);
    else passes++;
    chk_rs1 = 5'd0;
    drain("busy_stall");
  endtask

  task automatic test_back_to_back();
    exp_q.push_back('{rd: 5'd3,  data: 32'h0000_0031});
    exp_q.push_back('{rd: 5'd3,  data: 32'h0000_0032});
    exp_q.push_back('{rd: 5'd3,  data: 32'h0000_0033});
    exp_q.push_back('{rd: 5'd9,  data: 32'h0000_0099});
    exp_q.push_back('{rd: 5'd10, data: 32'h0000_0100});
    exp_q.push_back('{rd: 5'd11, data: 32'h0000_0111});
    alu_valid = 1'b1; alu_rd = 5'd3; alu_data = 32'h31;
    lsu_valid = 1'b1; lsu_rd = 5'd9; lsu_data = 32'h99;
    tick();
    alu_data = 32'h32; lsu_rd = 5'd10; lsu_data = 32'h100;
    checks++;
    if (lsu_ready !== 1'b1) $display("FAIL ready_one_entry: got %b, required 1", lsu_ready);
    else passes++;
    tick();
    alu_data = 32'h33; lsu_rd = 5'd11; lsu_data = 32'h111;
    checks++;
    if (lsu_ready !== 1'b0) $display("FAIL ready_full: got %b, required 0", lsu_ready);
    else passes++;
    tick();
    alu_valid = 1'b0;
    checks++;
    if (lsu_ready !== 1'b0) $display("FAIL ready_still_full: got %b, required 0", lsu_ready);
    else passes++;
    tick();
    checks++;
    if (lsu_ready !== 1'b1) $display("FAIL ready_after_pop: got %b, required 1", lsu_ready);
    else passes++;
    tick();
    lsu_valid = 1'b0;
    drain("back_to_back");
  endtask

  task automatic test_x0();
    issue_valid = 1'b1; issue_rd = 5'd0;
    tick();
    issue_valid = 1'b0;
    checks++;
    if (busy !== 32'd0) $display("FAIL issue_x0: got busy=%h, required 0", busy);
    else passes++;
    lsu_valid = 1'b1; lsu_rd = 5'd0; lsu_data = 32'h55;
    tick();
    lsu_valid = 1'b0;
    tick();
    checks++;
    if (rf_we !== 1'b0 || lsu_ready !== 1'b1)
      $display("FAIL lsu_x0_pop: got we=%b ready=%b, required 0/1", rf_we, lsu_ready);
    else passes++;
    lsu_valid = 1'b1; lsu_rd = 5'd4; lsu_data = 32'h44;
    tick();
    lsu_valid = 1'b0;
    alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 32'hBAD;
    exp_q.push_back('{rd: 5'd4, data: 32'h44});
    tick();
    alu_valid = 1'b0;
    checks++;
    if (rf_we !== 1'b1 || rf_rd !== 5'd4 || rf_wdata !== 32'h44)
      $display("FAIL alu_x0_drain: got we=%b rd=%0d data=%h, required 1/4/44", rf_we, rf_rd, rf_wdata);
    else passes++;
    drain("x0");
  endtask

  task automatic test_same_edge();
    issue_valid = 1'b1; issue_rd = 5'd12;
    tick();
    issue_valid = 1'b0;
    lsu_valid = 1'b1; lsu_rd = 5'd12; lsu_data = 32'hC0C0;
    tick();
    lsu_valid = 1'b0;
    issue_valid = 1'b1; issue_rd = 5'd12;
    exp_q.push_back('{rd: 5'd12, data: 32'hC0C0});
    tick();
    issue_valid = 1'b0;
    checks++;
    if (busy !== 32'h0000_1000 || rf_rd !== 5'd12)
      $display("FAIL same_edge_set_wins: got busy=%h rd=%0d, required 00001000/12", busy, rf_rd);
    else passes++;
    drain("same_edge");
  endtask

  task automatic test_reset_mid();
    issue_valid = 1'b1; issue_rd = 5'd6;
    alu_valid = 1'b1; alu_rd = 5'd1; alu_data = 32'h101;
    lsu_valid = 1'b1; lsu_rd = 5'd13; lsu_data = 32'hD;
    exp_q.push_back('{rd: 5'd1, data: 32'h101});
    tick();
    issue_valid = 1'b0;
    alu_data = 32'h102; lsu_rd = 5'd14; lsu_data = 32'hE;
    exp_q.push_back('{rd: 5'd1, data: 32'h102});
    tick();
    alu_valid = 1'b0; lsu_valid = 1'b0;
    checks++;
    if (busy[6] !== 1'b1 || lsu_ready !== 1'b0)
      $display("FAIL pre_reset_state: got busy6=%b ready=%b, required 1/0", busy[6], lsu_ready);
    else passes++;
    #5 rst = 1'b0;
    #1;
    checks++;
    if (rf_we !== 1'b0 || busy !== 32'd0 || lsu_ready !== 1'b0)
      $display("FAIL async_reset: got we=%b busy=%h ready=%b, required 0/0/0", rf_we, busy, lsu_ready);
    else passes++;
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      checks++;
      if (rf_we !== 1'b0 || lsu_ready !== 1'b1)
        $display("FAIL post_reset_cycle%0d: got we=%b ready=%b, required 0/1", k, rf_we, lsu_ready);
      else passes++;
    end
    drain("reset_mid");
  endtask

  initial begin
    rst = 1'b0;
    issue_valid = 1'b0; issue_rd = '0;
    alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
    lsu_valid = 1'b0; lsu_rd = '0; lsu_data = '0;
    chk_rs1 = '0; chk_rs2 = '0; chk_rd = '0;
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    test_alu();
    test_busy_stall();
    test_back_to_back();
    test_x0();
    test_same_edge();
    test_reset_mid();
    checks++;
    if (busy[0] !== 1'b0) $display("FAIL busy0: got %b, required 0", busy[0]);
    else passes++;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/writeback_unit.md
Name: writeback_unit

Overview:
- Writer side of the integer register file. It produces the `we`/`rd`/`data_rd` write stream that the register file consumes.
- It merges single-cycle ALU results with long-latency load/store-unit (LSU) results. LSU results are held in a small FIFO.
- It keeps a per-register busy scoreboard so decode can stall on pending long-latency destinations.

Parameters:
- XLEN, 32, data width of results and register write data.
- REG_ADDR_W, 5, register index width (32 architectural registers, x0 hardwired zero).
- LSU_FIFO_DEPTH, 2, entries buffering LSU results awaiting a write slot (power of two, >=2).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-low reset.
- issue_valid  in  1  decode issues a long-latency (LSU) op this cycle.
- issue_rd  in  REG_ADDR_W  destination of the issued long-latency op.
- alu_valid  in  1  ALU result valid; never back-pressured.
- alu_rd  in  REG_ADDR_W  ALU destination register.
- alu_data  in  XLEN  ALU result.
- lsu_valid  in  1  LSU result offered.
- lsu_ready  out  1  writeback can accept the LSU result.
- lsu_rd  in  REG_ADDR_W  LSU destination register.
- lsu_data  in  XLEN  LSU result.
- chk_rs1, chk_rs2, chk_rd  in  REG_ADDR_W  registers of the instruction in decode.
- stall  out  1  decode must hold the instruction.
- busy  out  32  scoreboard bit vector; bit 0 always 0.
- rf_we  out  1  register-file write enable.
- rf_rd  out  REG_ADDR_W  register-file destination.
- rf_wdata  out  XLEN  register-file write data.

Behaviour:
- Reset (rst low, asynchronous):
  - rf_we=0, rf_rd=0, rf_wdata=0, busy=0, lsu_ready=0.
  - FIFO emptied; contents discarded.
  - Applies mid-operation: pending LSU results and busy bits are lost.
  - First edge after release: lsu_ready=1.
- Write port outputs are registered. A result selected in cycle N appears on rf_* in cycle N+1. The register file writes it at the following edge.
- Arbitration, evaluated each cycle:
  - If alu_valid=1 and alu_rd!=0, the ALU result is selected.
  - Otherwise, if the FIFO is non-empty, the FIFO head is selected and popped.
  - Otherwise, rf_we=0 next cycle and rf_rd/rf_wdata hold their previous values.
- alu_valid with alu_rd=0: no write; the slot is treated as free, so the FIFO head may drain.
- FIFO head with rd=0: popped without a write, so rf_we=0 for that slot. busy is unaffected.
- LSU handshake:
  - Transfer occurs on an edge where lsu_valid=1 and lsu_ready=1.
  - lsu_ready = FIFO not full, from registered occupancy only; no combinational path from any input.
  - A push and a pop in the same cycle are both performed; occupancy is unchanged.
  - The LSU holds lsu_rd/lsu_data stable while lsu_valid=1 and lsu_ready=0.
- Scoreboard:
  - issue_valid=1 with issue_rd!=0 sets busy[issue_rd] at the edge.
  - Popping a FIFO head with rd!=0 clears busy[rd] at the same edge the entry is registered onto rf_*.
  - Same-edge set and clear of the same index: set wins.
  - busy[0] is constant 0.
  - An ALU write never changes busy.
- stall is combinational: busy[chk_rs1] | busy[chk_rs2] | busy[chk_rd], using the current registered busy. No bypass from an in-flight LSU pop.
- FIFO pointers wrap modulo LSU_FIFO_DEPTH. Occupancy counter width is clog2(DEPTH)+1.
- Starvation: continuous ALU writes may starve the FIFO. Decode guarantees bubbles, because stalled instructions create ALU-free cycles. The block itself applies no fairness.

Decomposition:
- Package wb_pkg holds:
  - constants XLEN and REG_ADDR_W;
  - typedef wb_entry_t, a packed struct {rd, data};
  - typedef busy_vec_t, a 32-bit vector.
- One sub-module, wb_fifo: a parameterised synchronous FIFO of wb_entry_t.
  - Ports: push, pop, full, empty, head.
  - Same asynchronous active-low reset.
- writeback_unit instantiates wb_fifo and contains the arbiter, scoreboard and output registers.

Test Plan:
- Reset release, then alu_valid=1, alu_rd=5, alu_data=0x0000_00AA for one cycle -> next cycle rf_we=1, rf_rd=5, rf_wdata=0xAA; following cycle rf_we=0.
- issue_valid with issue_rd=7 -> busy[7]=1. Drive chk_rs1=7 -> stall=1. LSU delivers rd=7, data=0xDEAD_BEEF with ALU idle -> rf_* shows it one cycle after the transfer, busy[7]=0 on that edge, stall=0.
- Collision: ALU rd=3 every cycle for 3 cycles while the LSU pushes rd=9 and rd=10 -> lsu_ready=0 after 2 pushes. Writes occur in order x3, x3, x3, x9, x10 once the ALU goes idle. The FIFO drains in order.
- x0 handling: issue_rd=0 -> busy unchanged. LSU rd=0 -> popped with rf_we=0. ALU rd=0 alongside a queued LSU rd=4 -> x4 written that slot.
- Same-edge set and clear on rd=12: pop LSU rd=12 while issue_valid with issue_rd=12 -> busy[12]=1 afterwards.
- Reset mid-operation: FIFO holding 2 entries and busy[6]=1, assert rst low between edges -> immediately rf_we=0, busy=0, lsu_ready=0. After release, no stale write appears.
